pipe_hazard_fwd_ctrl: RTL
=========================

Name: pipe_hazard_fwd_ctrl

Overview:
Parametrised hazard-detection and forwarding controller for the in-order ARM pipeline. It replaces the separate hazard and forwarding units with one block that tracks in-flight register writers in a DEPTH-entry scoreboard, so stall and forwarding decisions are made together. It sits beside the ID stage: it stalls the decoding instruction on unresolvable hazards and produces registered forwarding selects aligned to the EXE stage. It also counts stall and flush events.

Parameters:
NUM_SRC, 3, source-register operands checked per instruction (Rn, Rm, Rs)
DEPTH, 3, post-decode stages holding writers (0=EXE, 1=MEM, DEPTH-1=WB)
REG_AW, 4, register index width
LOAD_STAGE, 2, first stage index whose output can supply load data to a consumer in EXE
CNT_W, 32, width of the event counters
SELW, derived as clog2(DEPTH), width of one forwarding select

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
freeze  in  1  hold all state (pipeline frozen)
flush  in  1  branch taken; the ID instruction is killed
fwd_en  in  1  forwarding enable
id_valid  in  1  ID stage holds an instruction
id_wb_en  in  1  ID instruction writes a register
id_mem_r_en  in  1  ID instruction is a load
id_dest  in  REG_AW  ID destination register
id_src  in  NUM_SRC*REG_AW  packed source registers; source i is at [i*REG_AW +: REG_AW]
id_src_valid  in  NUM_SRC  source i is actually read
stall  out  1  combinational; hold IF/ID and insert a bubble into ID/EX
fwd_sel_q  out  NUM_SRC*SELW  registered; forwarding select per source for the instruction now in EXE
stall_cycles  out  CNT_W  saturating stall counter
flush_count  out  CNT_W  saturating flush counter

Behaviour:
- Scoreboard: sb[0..DEPTH-1], each entry {valid, wb_en, dest, is_load}. sb[k] describes the instruction in stage k.
- Reset (rst=0 at a clk edge): all sb.valid=0; fwd_sel_q=0; both counters=0; stall=0 follows from the empty scoreboard. Reset has priority over freeze and flush, including in the middle of a stall.
- Match for source i at stage k: id_src_valid[i] & sb[k].valid & sb[k].wb_en & sb[k].dest==src_i.
- WB-stage matches (k=DEPTH-1) never cause a hazard. The register file is write-through.
- Hazard with fwd_en=0: any match with k<=DEPTH-2.
- Hazard with fwd_en=1:
  - Take the youngest match (lowest k).
  - Stall if that producer is a load and k+1 < LOAD_STAGE.
  - Otherwise, forward with select k+1.
- stall = id_valid & (any source hazard). It is not gated by flush or freeze.
- Next select for source i: k+1 for the youngest match with k<=DEPTH-2 when fwd_en=1; otherwise 0. Encoding: 0 = register file, s = output of stage s.
- Update priority on each clk edge: rst > freeze > flush > stall > normal.
  - freeze: all state holds.
  - flush: shift sb[k+1]<=sb[k]; sb[0]<=bubble (valid=0); fwd_sel_q<=0; flush_count++.
  - stall (no flush): shift; sb[0]<=bubble; fwd_sel_q<=0; stall_cycles++.
  - normal: shift; sb[0]<={id_valid, id_wb_en, id_dest, id_mem_r_en}; fwd_sel_q<=next selects, or 0 if id_valid=0.
- The oldest entry, sb[DEPTH-1], falls off the end of the shift.
- Counters saturate at all-ones and do not wrap.
- Multiple sources may match different stages. Each source selects independently, and the stall is the OR across sources.
- With the default parameters, a load in EXE followed by a dependent instruction costs exactly one stall cycle with fwd_en=1. After that cycle the consumer receives fwd_sel_q=2 (forward from WB).
- id_dest==id_src of the same instruction causes no hazard. An instruction is checked only against older entries.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - sb_entry_t struct;
  - select encodings FWD_RF=0, FWD_MEM=1, FWD_WB=2;
  - the clog2-based SELW helper function.
- One sub-module, pipe_src_match (combinational), is instantiated NUM_SRC times. For one source it scans the scoreboard and outputs hazard plus select.
- All sequential state stays in the top.

Test Plan:
- ADD r1; then SUB reading r1 next cycle, fwd_en=1 -> stall=0; fwd_sel_q[src0]=1 while the SUB is in EXE.
- LDR r2; then ADD reading r2 next cycle, fwd_en=1 -> stall=1 for exactly 1 cycle; stall_cycles=1; fwd_sel_q[src0]=2 while the ADD is in EXE.
- Same as the first case with fwd_en=0 -> stall held for 2 cycles; fwd_sel_q=0; stall_cycles=2.
- Producer issued, then flush=1 while a dependent instruction sits in ID -> sb[0] becomes a bubble; flush_count=1; the instruction after the flush sees no hazard against the killed instruction.
- freeze=1 for 3 cycles during a pending stall -> scoreboard, fwd_sel_q and counters unchanged; stall stays 1. After freeze drops, the sequence resumes identically.
- Counter forced near all-ones plus continuous stall -> stall_cycles saturates at 2^CNT_W-1. rst=0 mid-stall -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/pipe_hazard_fwd_ctrl_pkg.sv
// rtl/pipe_hazard_fwd_ctrl_pkg.sv - shared types and encodings for the hazard/forwarding controller
// Purpose: scoreboard entry type, forwarding select encodings, select-width helper.
// Ports: none (package).
package pipe_ctrl_pkg;

  // Scoreboard dest field is sized for the widest register index we expect;
  // narrower REG_AW values are zero-extended on entry and on compare.
  localparam int SB_DEST_W = 8;

  // Forwarding select encodings: 0 = register file, s = output of stage s.
  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  typedef struct packed {
    logic                 valid;
    logic                 wb_en;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

  // Width of one forwarding select; never narrower than one bit.
  function automatic int sel_width(input int depth);
    if (depth <= 2) return 1;
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_hazard_fwd_ctrl_if.sv
// rtl/pipe_hazard_fwd_ctrl_if.sv - ID-stage bundle between decode and the hazard/forwarding controller
// Purpose: groups the pipeline control inputs, the ID instruction description and the controller outputs.
// Ports (master drives): freeze, flush, fwd_en, id_valid, id_wb_en, id_mem_r_en, id_dest, id_src, id_src_valid
// Ports (slave drives):  stall, fwd_sel_q, stall_cycles, flush_count
interface pipe_hazard_fwd_ctrl_if #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = 4,
  parameter int CNT_W   = 32,
  parameter int SELW    = pipe_ctrl_pkg::sel_width(DEPTH)
);
  logic                      freeze;
  logic                      flush;
  logic                      fwd_en;
  logic                      id_valid;
  logic                      id_wb_en;
  logic                      id_mem_r_en;
  logic [REG_AW-1:0]         id_dest;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_valid;
  logic                      stall;
  logic [NUM_SRC*SELW-1:0]   fwd_sel_q;
  logic [CNT_W-1:0]          stall_cycles;
  logic [CNT_W-1:0]          flush_count;

  modport master (
    output freeze, flush, fwd_en, id_valid, id_wb_en, id_mem_r_en, id_dest, id_src, id_src_valid,
    input  stall, fwd_sel_q, stall_cycles, flush_count
  );

  modport slave (
    input  freeze, flush, fwd_en, id_valid, id_wb_en, id_mem_r_en, id_dest, id_src, id_src_valid,
    output stall, fwd_sel_q, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_fwd_ctrl_src_match.sv
// rtl/pipe_hazard_fwd_ctrl_src_match.sv - per-source scoreboard scan producing hazard and forwarding select
// Purpose: finds the youngest in-flight writer of one source register and decides stall vs forward.
// Ports: fwd_en, src_valid, src (REG_AW), sb (DEPTH scoreboard entries) in; hazard, sel (SELW) out.
module pipe_src_match
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 4,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = 2
) (
  input  logic                  fwd_en,
  input  logic                  src_valid,
  input  logic [REG_AW-1:0]     src,
  input  sb_entry_t [DEPTH-1:0] sb,
  output logic                  hazard,
  output logic [SELW-1:0]       sel
);

  logic found;

  // The WB entry (DEPTH-1) is deliberately outside the scan: the register
  // file writes through, so a WB-stage producer is read as if already committed.
  always_comb begin
    hazard = 1'b0;
    sel    = SELW'(FWD_RF);
    found  = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (!found && src_valid && sb[k].valid && sb[k].wb_en &&
          (sb[k].dest == SB_DEST_W'(src))) begin
        found = 1'b1;
        if (!fwd_en) begin
          hazard = 1'b1;
        end else begin
          sel = SELW'(k + 1);
          // Load data only exists from LOAD_STAGE onward; forwarding from
          // stage k+1 is too early for a load until it gets there.
          if (sb[k].is_load && (k + 1 < LOAD_STAGE)) hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_fwd_ctrl.sv
// rtl/pipe_hazard_fwd_ctrl.sv - combined hazard detection and forwarding controller beside the ID stage
// Purpose: tracks in-flight writers in a DEPTH-entry scoreboard, stalls ID on unresolvable hazards,
//          registers per-source forwarding selects aligned to EXE, counts stall and flush events.
// Ports: clk, rst (sync, active-low); bus (slave modport: pipeline controls and ID instruction in,
//        stall / fwd_sel_q / stall_cycles / flush_count out).
module pipe_hazard_fwd_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 4,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_fwd_ctrl_if.slave bus
);

  localparam int SELW = sel_width(DEPTH);

  sb_entry_t [DEPTH-1:0]    sb_q;
  sb_entry_t                id_entry;
  logic [NUM_SRC-1:0]       src_hazard;
  logic [NUM_SRC*SELW-1:0]  next_sel;
  logic [NUM_SRC*SELW-1:0]  fwd_sel_q;
  logic [CNT_W-1:0]         stall_cnt_q;
  logic [CNT_W-1:0]         flush_cnt_q;
  logic                     stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    pipe_src_match #(
      .DEPTH      (DEPTH),
      .REG_AW     (REG_AW),
      .LOAD_STAGE (LOAD_STAGE),
      .SELW       (SELW)
    ) u_match (
      .fwd_en    (bus.fwd_en),
      .src_valid (bus.id_src_valid[i]),
      .src       (bus.id_src[i*REG_AW +: REG_AW]),
      .sb        (sb_q),
      .hazard    (src_hazard[i]),
      .sel       (next_sel[i*SELW +: SELW])
    );
  end

  // Stall is raw: flush and freeze decide separately what the edge does with it.
  assign stall = bus.id_valid & (|src_hazard);

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = bus.id_valid;
    id_entry.wb_en   = bus.id_wb_en;
    id_entry.dest    = SB_DEST_W'(bus.id_dest);
    id_entry.is_load = bus.id_mem_r_en;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_q        <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.freeze) begin
      // Every non-frozen edge advances the pipe; the oldest entry drops off.
      for (int k = DEPTH - 1; k > 0; k--) sb_q[k] <= sb_q[k-1];
      if (bus.flush) begin
        sb_q[0]     <= '0;
        fwd_sel_q   <= '0;
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end else if (stall) begin
        sb_q[0]     <= '0;
        fwd_sel_q   <= '0;
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end else begin
        sb_q[0]   <= id_entry;
        fwd_sel_q <= bus.id_valid ? next_sel : '0;
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.fwd_sel_q    = fwd_sel_q;
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule
